// File: rtl/hist_pkg.sv
// Shared widths, FSM state encoding and read-select codes for the frame analyzer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hist_pkg;

    localparam int NUM_BINS = 64;   // bins per frame, one beat each
    localparam int CNT_W    = 4;    // width of one bin count
    localparam int IDX_W    = 6;    // clog2(NUM_BINS)

    // Worst-case accumulator widths for 64 bins of 4-bit counts:
    // total <= 64*15 = 960, wsum <= 15*(0+..+63) = 30240, dividend = wsum*4.
    localparam int TOT_W    = 10;
    localparam int WSUM_W   = 15;
    localparam int DIV_W    = 17;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DIVIDE  = 2'd2
    } state_t;

    localparam logic [2:0] SEL_PEAK_IDX  = 3'd0;
    localparam logic [2:0] SEL_PEAK_CNT  = 3'd1;
    localparam logic [2:0] SEL_TOTAL_LO  = 3'd2;
    localparam logic [2:0] SEL_TOTAL_HI  = 3'd3;
    localparam logic [2:0] SEL_NZ        = 3'd4;
    localparam logic [2:0] SEL_MEAN      = 3'd5;
    localparam logic [2:0] SEL_STATUS    = 3'd6;
    localparam logic [2:0] SEL_FRAME_CNT = 3'd7;

endpackage

// File: rtl/hist_frame_analyzer_if.sv
// Bin-dump beat stream from the histogram block into the frame analyzer.
// Latency: n/a (wires only).
// Backpressure: none; the producer never stalls, the consumer must take every beat.
// Signals: s_valid (beat present), s_data (bin count, beat k = bin k), s_last (final beat).
interface hist_frame_analyzer_if;
    import hist_pkg::*;

    logic             s_valid;
    logic [CNT_W-1:0] s_data;
    logic             s_last;

    modport master (output s_valid, output s_data, output s_last);
    modport slave  (input  s_valid, input  s_data, input  s_last);

endinterface

// File: rtl/hist_seq_div.sv
// Restoring divider, one quotient bit per cycle; divide-by-zero yields quotient 0.
// Latency: start sampled on edge N, done pulses in the cycle after edge N+17.
// Backpressure: none; a new start while running restarts the division.
// Ports: clk, rst (sync, active-high), start, dividend[DIV_W], divisor[TOT_W],
//        done (1-cycle pulse), quotient[DIV_W] (held until the next start).
module hist_seq_div
    import hist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [TOT_W-1:0] divisor,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    logic [DIV_W-1:0] quo;
    logic [TOT_W-1:0] rem;
    logic [TOT_W-1:0] den;
    logic [4:0]       iter;
    logic             running;
    logic             den_zero;

    logic [TOT_W:0]   rem_sh;
    logic [TOT_W-1:0] rem_sub;
    logic             fits;

    // The remainder stays below the divisor, so after a successful subtract
    // the low TOT_W bits hold the exact result even though rem_sh is wider.
    always_comb begin
        rem_sh  = {rem, quo[DIV_W-1]};
        fits    = (rem_sh >= {1'b0, den});
        rem_sub = rem_sh[TOT_W-1:0] - den;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo      <= '0;
            rem      <= '0;
            den      <= '0;
            iter     <= '0;
            running  <= 1'b0;
            den_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo      <= dividend;
                rem      <= '0;
                den      <= divisor;
                den_zero <= (divisor == '0);
                iter     <= 5'(DIV_W);
                running  <= 1'b1;
            end else if (running) begin
                if (fits) begin
                    rem <= rem_sub;
                    quo <= {quo[DIV_W-2:0], 1'b1};
                end else begin
                    rem <= rem_sh[TOT_W-1:0];
                    quo <= {quo[DIV_W-2:0], 1'b0};
                end
                iter <= iter - 5'd1;
                if (iter == 5'd1) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    // With a zero divisor every step "fits", so the raw quotient is all ones.
    assign quotient = den_zero ? '0 : quo;

endmodule

// File: rtl/hist_frame_analyzer.sv
// Reduces each 64-beat histogram frame to peak/total/non-zero/mean/frame-count results.
// Latency: results commit and done pulses 18 edges after the last-beat edge.
// Backpressure: none; beats arriving during the divide are dropped and flagged as overrun.
// Ports: clk, rst (sync, active-high), bin_in (beat stream, slave), err_clr,
//        rd_sel/rd_data (byte-wide result read), done, busy (dividing), err (sticky).
module hist_frame_analyzer
    import hist_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    hist_frame_analyzer_if.slave        bin_in,
    input  logic                        err_clr,
    input  logic [2:0]                  rd_sel,
    output logic [7:0]                  rd_data,
    output logic                        done,
    output logic                        busy,
    output logic                        err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

    state_t state;

    // Working accumulators for the frame in flight.
    logic [IDX_W-1:0]  beat_idx;
    logic [TOT_W-1:0]  total;
    logic [WSUM_W-1:0] wsum;
    logic [6:0]        nz;
    logic [IDX_W-1:0]  acc_peak_idx;
    logic [CNT_W-1:0]  acc_peak_cnt;

    // Committed results, only touched when done fires.
    logic [IDX_W-1:0]  res_peak_idx;
    logic [CNT_W-1:0]  res_peak_cnt;
    logic [TOT_W-1:0]  res_total;
    logic [6:0]        res_nz;
    logic [7:0]        res_mean;
    logic [7:0]        frame_cnt;
    logic              result_valid;
    logic              err_len;
    logic              err_ovr;

    logic [IDX_W+CNT_W-1:0] prod;
    logic [TOT_W-1:0]       total_nx;
    logic [WSUM_W-1:0]      wsum_nx;
    logic [6:0]             nz_nx;
    logic                   peak_take;
    logic                   beat_last;
    logic                   in_collect;
    logic                   len_set;
    logic                   long_frame;
    logic                   ovr_set;
    logic                   div_start;
    logic                   div_done;
    logic [DIV_W-1:0]       div_quo;
    logic                   acc_load;
    logic                   acc_clr;

    always_comb begin
        prod       = {{CNT_W{1'b0}}, beat_idx} * {{IDX_W{1'b0}}, bin_in.s_data};
        total_nx   = total + TOT_W'(bin_in.s_data);
        wsum_nx    = wsum + WSUM_W'(prod);
        nz_nx      = nz + 7'(bin_in.s_data != '0);
        // Strict compare keeps the lowest index on ties; beat 0 always seeds the peak.
        peak_take  = (beat_idx == '0) || (bin_in.s_data > acc_peak_cnt);
        beat_last  = (beat_idx == LAST_IDX);
        in_collect = (state == COLLECT) && bin_in.s_valid;
        // Length error: last flag and 64th beat disagree (short or long frame).
        len_set    = in_collect && (bin_in.s_last != beat_last);
        long_frame = in_collect && beat_last && !bin_in.s_last;
        div_start  = in_collect && bin_in.s_last && beat_last;
        ovr_set    = (state == DIVIDE) && bin_in.s_valid;
        acc_load   = in_collect && !len_set;
        acc_clr    = (in_collect && len_set) || ((state == DIVIDE) && div_done);
    end

    // The divider sees the sums including the final beat, taken combinationally.
    hist_seq_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({wsum_nx, 2'b00}),
        .divisor  (total_nx),
        .done     (div_done),
        .quotient (div_quo)
    );

    // Mean is deliberately truncated to its low byte.
    logic unused_quo_hi;
    assign unused_quo_hi = ^div_quo[DIV_W-1:8];

    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            beat_idx     <= '0;
            total        <= '0;
            wsum         <= '0;
            nz           <= '0;
            acc_peak_idx <= '0;
            acc_peak_cnt <= '0;
        end else if (acc_load) begin
            beat_idx <= beat_idx + IDX_W'(1);
            total    <= total_nx;
            wsum     <= wsum_nx;
            nz       <= nz_nx;
            if (peak_take) begin
                acc_peak_idx <= beat_idx;
                acc_peak_cnt <= bin_in.s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= COLLECT;
            done         <= 1'b0;
            busy         <= 1'b0;
            res_peak_idx <= '0;
            res_peak_cnt <= '0;
            res_total    <= '0;
            res_nz       <= '0;
            res_mean     <= '0;
            frame_cnt    <= '0;
            result_valid <= 1'b0;
            err_len      <= 1'b0;
            err_ovr      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                COLLECT: begin
                    if (div_start) begin
                        state <= DIVIDE;
                        busy  <= 1'b1;
                    end else if (long_frame) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bin_in.s_valid && bin_in.s_last) begin
                        state <= COLLECT;
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        res_peak_idx <= acc_peak_idx;
                        res_peak_cnt <= acc_peak_cnt;
                        res_total    <= total;
                        res_nz       <= nz;
                        res_mean     <= div_quo[7:0];
                        frame_cnt    <= frame_cnt + 8'd1;
                        result_valid <= 1'b1;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                    busy  <= 1'b0;
                end
            endcase

            // A set event in the same cycle as err_clr keeps the bit set.
            if (len_set) begin
                err_len <= 1'b1;
            end else if (err_clr) begin
                err_len <= 1'b0;
            end
            if (ovr_set) begin
                err_ovr <= 1'b1;
            end else if (err_clr) begin
                err_ovr <= 1'b0;
            end
        end
    end

    assign err = err_len | err_ovr;

    always_comb begin
        rd_data = 8'h00;
        case (rd_sel)
            SEL_PEAK_IDX:  rd_data = {2'b00, res_peak_idx};
            SEL_PEAK_CNT:  rd_data = {4'b0000, res_peak_cnt};
            SEL_TOTAL_LO:  rd_data = res_total[7:0];
            SEL_TOTAL_HI:  rd_data = {6'b000000, res_total[9:8]};
            SEL_NZ:        rd_data = {1'b0, res_nz};
            SEL_MEAN:      rd_data = res_mean;
            SEL_STATUS:    rd_data = {5'b00000, err_ovr, err_len, result_valid};
            SEL_FRAME_CNT: rd_data = frame_cnt;
            default:       rd_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_hist_frame_analyzer.sv
// Directed bench for hist_frame_analyzer: frame statistics, timing, errors and wrap.
// Latency: checks done arrives 18 edges after the last beat.
// Backpressure: none exercised beyond beats injected during the divide.
module tb_hist_frame_analyzer;
    import hist_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       err_clr;
    logic [2:0] rd_sel;
    logic [7:0] rd_data;
    logic       done;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [3:0] fr [64];

    hist_frame_analyzer_if bus ();

    hist_frame_analyzer dut (
        .clk     (clk),
        .rst     (rst),
        .bin_in  (bus),
        .err_clr (err_clr),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .done    (done),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic fill_frame(input logic [3:0] v);
        for (int i = 0; i < 64; i++) fr[i] = v;
    endtask

    task automatic pattern_a();
        fill_frame(4'd0);
        fr[10] = 4'd15;
        fr[20] = 4'd3;
    endtask

    task automatic pattern_tie();
        fill_frame(4'd1);
        fr[5]  = 4'd15;
        fr[40] = 4'd15;
    endtask

    // Beats change on negedges; the beat with index last_at carries s_last.
    task automatic drive_frame(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = fr[i % 64];
            bus.s_last  = (i == last_at);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = 4'd0;
        bus.s_last  = 1'b0;
    endtask

    // Counts posedges until done is seen; lat = -1 if the budget runs out.
    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic rd(input int sel, output logic [7:0] v);
        rd_sel = sel[2:0];
        #1;
        v = rd_data;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("FAIL reset_sel%0d: got %02h want 00", i, v);
            end
        end
        checks++;
        if ({done, busy, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: done/busy/err got %b want 000", {done, busy, err});
        end
    endtask

    task automatic test_basic();
        logic [7:0] v;
        logic [7:0] exp [8];
        int lat;
        exp = '{8'h0A, 8'h0F, 8'h12, 8'h00, 8'h02, 8'h2E, 8'h01, 8'h01};
        pattern_a();
        drive_frame(64, 63);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        wait_done(40, lat);
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges want 18", lat);
        end
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            checks++;
            if (v !== exp[i]) begin
                errors++;
                $display("FAIL basic_sel%0d: got %02h want %02h", i, v, exp[i]);
            end
        end
    endtask

    task automatic test_tie_and_full();
        logic [7:0] v;
        logic [7:0] exp [8];
        int lat;
        exp = '{8'h05, 8'h0F, 8'h5C, 8'h00, 8'h40, 8'h73, 8'h01, 8'h02};
        pattern_tie();
        drive_frame(64, 63);
        wait_done(40, lat);
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            checks++;
            if (v !== exp[i]) begin
                errors++;
                $display("FAIL tie_sel%0d: got %02h want %02h", i, v, exp[i]);
            end
        end
        exp = '{8'h00, 8'h0F, 8'hC0, 8'h03, 8'h40, 8'h7E, 8'h01, 8'h03};
        fill_frame(4'd15);
        drive_frame(64, 63);
        wait_done(40, lat);
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            checks++;
            if (v !== exp[i]) begin
                errors++;
                $display("FAIL full_sel%0d: got %02h want %02h", i, v, exp[i]);
            end
        end
    endtask

    task automatic test_short_frame();
        logic [7:0] v;
        logic [7:0] exp [8];
        int lat;
        exp = '{8'h00, 8'h0F, 8'hC0, 8'h03, 8'h40, 8'h7E, 8'h03, 8'h03};
        pattern_a();
        drive_frame(31, 30);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL short_err: got %b want 1", err);
        end
        wait_done(25, lat);
        checks++;
        if (lat !== -1) begin
            errors++;
            $display("FAIL short_no_done: done seen after %0d edges, want none", lat);
        end
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            checks++;
            if (v !== exp[i]) begin
                errors++;
                $display("FAIL short_sel%0d: got %02h want %02h", i, v, exp[i]);
            end
        end
        exp = '{8'h0A, 8'h0F, 8'h12, 8'h00, 8'h02, 8'h2E, 8'h03, 8'h04};
        drive_frame(64, 63);
        wait_done(40, lat);
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL short_recover_latency: got %0d edges want 18", lat);
        end
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            checks++;
            if (v !== exp[i]) begin
                errors++;
                $display("FAIL short_recover_sel%0d: got %02h want %02h", i, v, exp[i]);
            end
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        rd(6, v);
        checks++;
        if (v !== 8'h01 || err !== 1'b0) begin
            errors++;
            $display("FAIL short_err_clr: sel6 got %02h err %b want 01 err 0", v, err);
        end
    endtask

    task automatic test_long_and_overrun();
        logic [7:0] v;
        logic [7:0] exp [8];
        int lat;
        pattern_a();
        drive_frame(68, 67);
        wait_done(25, lat);
        checks++;
        if (lat !== -1) begin
            errors++;
            $display("FAIL long_no_done: done seen after %0d edges, want none", lat);
        end
        rd(6, v);
        checks++;
        if (v !== 8'h03 || err !== 1'b1) begin
            errors++;
            $display("FAIL long_status: sel6 got %02h err %b want 03 err 1", v, err);
        end
        rd(7, v);
        checks++;
        if (v !== 8'h04) begin
            errors++;
            $display("FAIL long_frame_cnt: got %02h want 04", v);
        end
        // A clean frame after the drain must not carry any of the discarded beats.
        exp = '{8'h05, 8'h0F, 8'h5C, 8'h00, 8'h40, 8'h73, 8'h03, 8'h05};
        pattern_tie();
        drive_frame(64, 63);
        wait_done(40, lat);
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            checks++;
            if (v !== exp[i]) begin
                errors++;
                $display("FAIL after_long_sel%0d: got %02h want %02h", i, v, exp[i]);
            end
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        exp = '{8'h0A, 8'h0F, 8'h12, 8'h00, 8'h02, 8'h2E, 8'h05, 8'h06};
        pattern_a();
        drive_frame(64, 63);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 4'd15;
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = 4'd0;
        wait_done(40, lat);
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL ovr_done: got no done want done");
        end
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            checks++;
            if (v !== exp[i]) begin
                errors++;
                $display("FAIL ovr_sel%0d: got %02h want %02h", i, v, exp[i]);
            end
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL ovr_err: got %b want 1", err);
        end
    endtask

    task automatic test_reset_mid_divide();
        logic [7:0] v;
        int lat;
        pattern_a();
        drive_frame(64, 63);
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL middiv_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_done(25, lat);
        checks++;
        if (lat !== -1) begin
            errors++;
            $display("FAIL middiv_no_done: done seen after %0d edges, want none", lat);
        end
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("FAIL middiv_sel%0d: got %02h want 00", i, v);
            end
        end
        checks++;
        if ({busy, err} !== 2'b00) begin
            errors++;
            $display("FAIL middiv_flags: busy/err got %b want 00", {busy, err});
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [7:0] v;
        logic [7:0] exp [8];
        int lat;
        int missed;
        // All-zero frames: total 0 exercises the forced-zero mean path.
        exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
        fill_frame(4'd0);
        drive_frame(64, 63);
        wait_done(40, lat);
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL zero_latency: got %0d edges want 18", lat);
        end
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            checks++;
            if (v !== exp[i]) begin
                errors++;
                $display("FAIL zero_sel%0d: got %02h want %02h", i, v, exp[i]);
            end
        end
        missed = 0;
        for (int f = 1; f < 255; f++) begin
            drive_frame(64, 63);
            wait_done(40, lat);
            if (lat < 0) missed++;
        end
        checks++;
        if (missed !== 0) begin
            errors++;
            $display("FAIL wrap_missed_done: got %0d frames without done want 0", missed);
        end
        rd(7, v);
        checks++;
        if (v !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_cnt_255: got %02h want ff", v);
        end
        drive_frame(64, 63);
        wait_done(40, lat);
        rd(7, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL wrap_cnt_0: got %02h want 00", v);
        end
    endtask

    initial begin
        rst         = 1'b1;
        err_clr     = 1'b0;
        rd_sel      = 3'd0;
        bus.s_valid = 1'b0;
        bus.s_data  = 4'd0;
        bus.s_last  = 1'b0;
        test_reset();
        test_basic();
        test_tie_and_full();
        test_short_frame();
        test_long_and_overrun();
        test_reset_mid_divide();
        test_back_to_back_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
